// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game controller: pattern width, win count,
// controller state encoding and the saturating score increment.
package memory_game_pkg;

  localparam int PAT_W       = 10;
  localparam int SCORE_W     = 4;
  localparam int MAX_ENTRIES = 10;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v,
    input logic [SCORE_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer: the output follows the input only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output. Clears to released (high).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
      r_out <= 1'b1;
    end else if (in == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_out <= in;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out = r_out;

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game controller: debounced key presses submit switch patterns; unique
// patterns are written to number_mem and scored, a repeat ends the game.
module memory_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_ENTRIES     = memory_game_pkg::MAX_ENTRIES
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic [memory_game_pkg::PAT_W-1:0]   sw,
  input  logic                                key,
  input  logic                                exist,
  output logic [memory_game_pkg::PAT_W-1:0]   cand,
  output logic [memory_game_pkg::SCORE_W-1:0] wn,
  output logic                                we,
  output logic                                mem_clrn,
  output logic [memory_game_pkg::SCORE_W-1:0] score,
  output logic                                game_over,
  output logic                                win,
  output logic                                reject,
  output logic [2:0]                          o_dbg_state
);

  import memory_game_pkg::*;

  // Arming needs DEBOUNCE_CYCLES real high samples plus the two reset-value
  // samples still flushing out of the synchronizer.
  localparam int ARM_N = DEBOUNCE_CYCLES + 2;
  localparam int ARM_W = $clog2(ARM_N + 1);
  localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_N - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(MAX_ENTRIES);

  logic               r_sync1;
  logic               r_sync2;
  logic               w_key_db;
  logic               r_key_db_d;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic               r_armed;
  logic               w_press;

  state_t             r_state;
  state_t             w_next;
  logic [PAT_W-1:0]   r_cand;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_inc;
  logic               r_reject;
  logic               w_sw_zero;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk(clk),
    .clr(clr),
    .in (r_sync2),
    .out(w_key_db)
  );

  // A key held through reset stays unarmed until it has been seen released.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_key_db_d <= 1'b1;
      r_arm_cnt  <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_key_db_d <= w_key_db;
      if (!r_armed) begin
        if (!r_sync2) begin
          r_arm_cnt <= '0;
        end else if (r_arm_cnt == ARM_LAST) begin
          r_armed <= 1'b1;
        end else begin
          r_arm_cnt <= r_arm_cnt + 1'b1;
        end
      end
    end
  end

  assign w_press     = r_armed & r_key_db_d & ~w_key_db;
  assign w_sw_zero   = (sw == '0);
  assign w_score_inc = sat_inc(r_score, MAX_SCORE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_CLEAR: w_next = ST_PLAY;
      ST_PLAY:  if (w_press && !w_sw_zero) w_next = ST_CHECK;
      ST_CHECK: w_next = exist ? ST_OVER : ST_WRITE;
      ST_WRITE: w_next = (w_score_inc == MAX_SCORE) ? ST_WIN : ST_PLAY;
      ST_OVER:  if (w_press) w_next = ST_CLEAR;
      ST_WIN:   if (w_press) w_next = ST_CLEAR;
      default:  w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_CLEAR;
      r_cand   <= '0;
      r_score  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_reject <= (r_state == ST_PLAY) && w_press && w_sw_zero;
      if ((r_state == ST_PLAY) && w_press && !w_sw_zero) begin
        r_cand <= sw;
      end
      if (r_state == ST_CLEAR) begin
        r_score <= '0;
      end else if (r_state == ST_WRITE) begin
        r_score <= w_score_inc;
      end
    end
  end

  // Moore outputs: only registered state feeds we and mem_clrn, so they are disjoint.
  assign cand        = r_cand;
  assign wn          = r_score;
  assign score       = r_score;
  assign we          = (r_state == ST_WRITE);
  assign mem_clrn    = (r_state != ST_CLEAR);
  assign game_over   = (r_state == ST_OVER);
  assign win         = (r_state == ST_WIN);
  assign reject      = r_reject;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: emulates number_mem, predicts every output from a
// behavioural game model, and adds directed and randomized key/switch stimulus.
module tb_memory_game_ctrl;
  import memory_game_pkg::*;

  localparam int DEB  = 4;
  localparam int MAXE = 10;

  localparam int P_CLEAR = 0;
  localparam int P_PLAY  = 1;
  localparam int P_CHECK = 2;
  localparam int P_WRITE = 3;
  localparam int P_OVER  = 4;
  localparam int P_WIN   = 5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       key = 1'b1;
  logic       force_exist = 1'b0;
  logic [9:0] sw = '0;
  logic       exist;
  logic       env_hit;

  logic [9:0] cand;
  logic [3:0] wn;
  logic       we;
  logic       mem_clrn;
  logic [3:0] score;
  logic       game_over;
  logic       win;
  logic       reject;
  logic [2:0] o_dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int rej_cnt = 0;
  int clrn_low_cnt = 0;

  always #5 clk = ~clk;

  memory_game_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_ENTRIES    (MAXE)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .sw         (sw),
    .key        (key),
    .exist      (exist),
    .cand       (cand),
    .wn         (wn),
    .we         (we),
    .mem_clrn   (mem_clrn),
    .score      (score),
    .game_over  (game_over),
    .win        (win),
    .reject     (reject),
    .o_dbg_state(o_dbg_state)
  );

  // number_mem stand-in
  logic [9:0] env_mem [MAXE];

  always @(posedge clk) begin
    if (!mem_clrn) begin
      for (int i = 0; i < MAXE; i++) env_mem[i] <= '0;
    end else if (we && (int'(wn) < MAXE)) begin
      env_mem[wn] <= cand;
    end
  end

  always_comb begin
    env_hit = 1'b0;
    for (int i = 0; i < MAXE; i++) if (env_mem[i] == cand) env_hit = 1'b1;
  end

  assign exist = force_exist | env_hit;

  // behavioural model
  int         m_phase = P_CLEAR;
  logic [9:0] m_cand  = '0;
  int         m_score = 0;
  bit         m_reject = 1'b0;
  logic [9:0] m_set[$];
  bit         kq[$];
  bit         win_q[$];
  bit         m_level = 1'b1;
  int         hi_run = 0;
  bit         armed = 1'b0;
  bit         press_pend = 1'b0;

  function automatic bit set_has(input logic [9:0] v);
    foreach (m_set[i]) if (m_set[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit p;
    bit ex;
    bit ds;
    bit fell;
    bit same;
    p  = press_pend;
    ex = force_exist | set_has(m_cand);
    if (m_phase == P_CLEAR) m_set.delete();
    else if (m_phase == P_WRITE) m_set.push_back(m_cand);
    if (clr) begin
      m_phase = P_CLEAR;
      m_cand = '0;
      m_score = 0;
      m_reject = 1'b0;
      kq.delete();
      kq.push_back(1'b1);
      kq.push_back(1'b1);
      win_q.delete();
      m_level = 1'b1;
      hi_run = 0;
      armed = 1'b0;
      press_pend = 1'b0;
    end else begin
      m_reject = 1'b0;
      case (m_phase)
        P_CLEAR: begin m_score = 0; m_phase = P_PLAY; end
        P_PLAY: if (p) begin
          if (sw != 0) begin m_cand = sw; m_phase = P_CHECK; end
          else m_reject = 1'b1;
        end
        P_CHECK: m_phase = ex ? P_OVER : P_WRITE;
        P_WRITE: begin
          if (m_score < MAXE) m_score++;
          m_phase = (m_score == MAXE) ? P_WIN : P_PLAY;
        end
        default: if (p) m_phase = P_CLEAR;
      endcase
      // key level seen by the debouncer lags the pin by two samples
      ds = kq.pop_front();
      kq.push_back(key);
      hi_run = ds ? hi_run + 1 : 0;
      if (hi_run >= DEB + 2) armed = 1'b1;
      win_q.push_back(ds);
      if (win_q.size() > DEB) void'(win_q.pop_front());
      fell = 1'b0;
      if (win_q.size() == DEB) begin
        same = 1'b1;
        foreach (win_q[i]) if (win_q[i] != win_q[0]) same = 1'b0;
        if (same && (win_q[0] != m_level)) begin
          fell = m_level;
          m_level = win_q[0];
        end
      end
      press_pend = armed & fell;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    chk("cand", int'(cand), int'(m_cand));
    chk("wn", int'(wn), m_score % 16);
    chk("we", int'(we), int'(m_phase == P_WRITE));
    chk("mem_clrn", int'(mem_clrn), int'(m_phase != P_CLEAR));
    chk("score", int'(score), m_score);
    chk("game_over", int'(game_over), int'(m_phase == P_OVER));
    chk("win", int'(win), int'(m_phase == P_WIN));
    chk("reject", int'(reject), int'(m_reject));
    we_cnt       += int'(we);
    rej_cnt      += int'(reject);
    clrn_low_cnt += int'(!mem_clrn);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] p);
    sw  = p;
    key = 1'b0;
    tick(DEB + 4);
    key = 1'b1;
    tick(DEB + 8);
  endtask

  initial begin
    int lat;
    int w0;
    int r0;
    int c0;
    bit found;
    logic [9:0] used[$];
    logic [9:0] pat;

    for (int i = 0; i < MAXE; i++) env_mem[i] = '0;
    tick(3);
    chk("rst_score", int'(score), 0);
    chk("rst_cand", int'(cand), 0);
    chk("rst_wn", int'(wn), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_mem_clrn", int'(mem_clrn), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_reject", int'(reject), 0);
    clr = 1'b0;
    tick(10);

    // 2 sync + 4 debounce samples to the press, then CHECK, then WRITE
    sw = 10'h001;
    key = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick(1);
      if (we) lat = i;
    end
    chk("press_to_we_latency", lat, 8);
    chk("first_we_wn", int'(wn), 0);
    chk("first_we_cand", int'(cand), 10'h001);
    key = 1'b1;
    tick(12);
    chk("first_score", int'(score), 1);

    w0 = we_cnt;
    force_exist = 1'b1;
    press(10'h001);
    chk("dup_game_over", int'(game_over), 1);
    chk("dup_no_write", we_cnt - w0, 0);
    chk("dup_score_kept", int'(score), 1);
    force_exist = 1'b0;
    press(10'h155);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_score", int'(score), 0);

    r0 = rej_cnt;
    w0 = we_cnt;
    press(10'h000);
    chk("zero_reject_pulse", rej_cnt - r0, 1);
    chk("zero_no_write", we_cnt - w0, 0);
    chk("zero_state_play", int'(o_dbg_state), int'(ST_PLAY));

    for (int i = 0; i < 10; i++) press(10'h010 + 10'(i));
    chk("win_score", int'(score), 10);
    chk("win_flag", int'(win), 1);
    c0 = clrn_low_cnt;
    press(10'h3ff);
    chk("newgame_clrn_cycles", clrn_low_cnt - c0, 1);
    chk("newgame_score", int'(score), 0);
    chk("newgame_state_play", int'(o_dbg_state), int'(ST_PLAY));

    r0 = rej_cnt;
    sw = '0;
    key = 1'b0; tick(3);
    key = 1'b1; tick(10);
    chk("short_bounce_no_press", rej_cnt - r0, 0);
    key = 1'b0; tick(1);
    key = 1'b1; tick(1);
    key = 1'b0; tick(1);
    key = 1'b1; tick(1);
    key = 1'b0; tick(6);
    key = 1'b1; tick(12);
    chk("bounce_then_stable_one_press", rej_cnt - r0, 1);

    sw = 10'h2a5;
    key = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (we) found = 1'b1;
    end
    chk("reached_write", int'(found), 1);
    c0 = clrn_low_cnt;
    clr = 1'b1;
    tick(1);
    chk("clr_in_write_we_off", int'(we), 0);
    chk("clr_in_write_clrn_low", int'(mem_clrn), 0);
    clr = 1'b0;
    key = 1'b1;
    tick(10);
    chk("clr_in_write_clrn_once", clrn_low_cnt - c0, 1);
    chk("clr_in_write_score", int'(score), 0);

    r0 = rej_cnt;
    sw = '0;
    key = 1'b0;
    clr = 1'b1;
    tick(3);
    clr = 1'b0;
    tick(15);
    chk("held_through_reset_no_press", rej_cnt - r0, 0);
    key = 1'b1;
    tick(10);
    press(10'h000);
    chk("press_after_release", rej_cnt - r0, 1);

    for (int it = 0; it < 300; it++) begin
      force_exist = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) < 3) begin
        clr = 1'b1;
        tick($urandom_range(1, 3));
        clr = 1'b0;
      end else begin
        case ($urandom_range(0, 9))
          0, 1: pat = '0;
          2, 3: pat = (used.size() > 0) ? used[$urandom_range(0, used.size() - 1)]
                                        : 10'($urandom_range(1, 1023));
          default: pat = 10'($urandom_range(1, 1023));
        endcase
        if (pat != 0) used.push_back(pat);
        if (used.size() > 16) void'(used.pop_front());
        sw = pat;
        if ($urandom_range(0, 3) == 0) begin
          key = 1'b0; tick($urandom_range(1, 2));
          key = 1'b1; tick(1);
        end
        key = 1'b0;
        tick($urandom_range(1, 8));
        key = 1'b1;
        tick($urandom_range(1, 12));
      end
    end
    force_exist = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
